// File: rtl/project1_pkg.sv
// Shared types and constants for the Project1 button input stage.
package project1_pkg;

    typedef enum logic [1:0] {
        DB_REL    = 2'd0,
        DB_PEND_P = 2'd1,
        DB_PRS    = 2'd2,
        DB_PEND_R = 2'd3
    } db_state_e;

    // View-select codes in result multiplexer input order
    localparam logic [1:0] VIEW_MO = 2'd0;
    localparam logic [1:0] VIEW_CO = 2'd1;
    localparam logic [1:0] VIEW_LO = 2'd2;
    localparam logic [1:0] VIEW_AO = 2'd3;

    localparam int unsigned BTN_CAPTURE = 0;
    localparam int unsigned BTN_VIEW    = 1;

    // Counter width able to hold 0..n-1, never less than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, debounce FSM with hold counter, press pulse.
// BUTTON_AUTOREPEAT_EN adds a repeat request input and a PRS-state output.
module btn_debounce
    import project1_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
`ifdef BUTTON_AUTOREPEAT_EN
    input  logic repeat_req,
    output logic prs_c,
`endif
    output logic press,
    output logic held,
    output logic press_c
);

    localparam int unsigned CNT_W = cnt_width(DB_CYCLES);

    logic [1:0]       sync_q;
    logic             level;
    db_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             hit;
    logic             enter_prs;

    // Synchroniser resets to the released (high) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n};
        end
    end

    assign level = ~sync_q[1];
    assign hit   = (cnt == CNT_W'(DB_CYCLES - 1));

    // Next state; counter clears on every state change
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        enter_prs = 1'b0;
        case (state)
            DB_REL: begin
                if (level) state_nxt = DB_PEND_P;
            end
            DB_PEND_P: begin
                if (!level) begin
                    state_nxt = DB_REL;
                end else if (hit) begin
                    state_nxt = DB_PRS;
                    enter_prs = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DB_PRS: begin
                if (!level) state_nxt = DB_PEND_R;
            end
            DB_PEND_R: begin
                if (level) begin
                    state_nxt = DB_PRS;
                end else if (hit) begin
                    state_nxt = DB_REL;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = DB_REL;
        endcase
    end

`ifdef BUTTON_AUTOREPEAT_EN
    assign prs_c   = (state == DB_PRS);
    assign press_c = enter_prs | (prs_c & repeat_req);
`else
    assign press_c = enter_prs;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DB_REL;
            cnt   <= '0;
            press <= 1'b0;
            held  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            press <= press_c;
            held  <= (state_nxt == DB_PRS) || (state_nxt == DB_PEND_R);
        end
    end

endmodule

// File: rtl/button_input_stage.sv
// Button conditioning, view-select counter and switch capture for Project1.
// Define BUTTON_AUTOREPEAT_EN to auto-repeat the view-step button while held.
module button_input_stage
    import project1_pkg::*;
#(
    parameter int unsigned NUM_BTN       = 2,
    parameter int unsigned DB_CYCLES     = 500000,
    parameter int unsigned REPEAT_CYCLES = 25000000,
    parameter int unsigned OP_W          = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] buttons,
    input  logic [9:0]         switches,
    output logic [NUM_BTN-1:0] press,
    output logic [NUM_BTN-1:0] held,
    output logic [1:0]         sel,
    output logic [OP_W-1:0]    operand,
    output logic [1:0]         mode,
    output logic               capture_valid
);

    logic [NUM_BTN-1:0] press_c;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int unsigned        RPT_W    = cnt_width(REPEAT_CYCLES);
    localparam logic [NUM_BTN-1:0] RPT_MASK = NUM_BTN'(1) << BTN_VIEW;

    logic [NUM_BTN-1:0] prs;
    logic [NUM_BTN-1:0] rep_req;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
`ifdef BUTTON_AUTOREPEAT_EN
        logic [RPT_W-1:0] rpt_cnt;
        logic             rpt_hit;

        // Repeat counter runs only while stable-pressed; masked buttons never repeat
        assign rpt_hit    = prs[i] && (rpt_cnt == RPT_W'(REPEAT_CYCLES - 1));
        assign rep_req[i] = RPT_MASK[i] && rpt_hit;

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                rpt_cnt <= '0;
            end else if (!prs[i] || rpt_hit) begin
                rpt_cnt <= '0;
            end else begin
                rpt_cnt <= rpt_cnt + RPT_W'(1);
            end
        end
`endif

        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk        (clock),
            .rst_n      (reset_n),
            .btn_n      (buttons[i]),
`ifdef BUTTON_AUTOREPEAT_EN
            .repeat_req (rep_req[i]),
            .prs_c      (prs[i]),
`endif
            .press      (press[i]),
            .held       (held[i]),
            .press_c    (press_c[i])
        );
    end

    // Capture and view step act on the same edge that raises the press pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sel           <= VIEW_MO;
            operand       <= '0;
            mode          <= 2'b00;
            capture_valid <= 1'b0;
        end else begin
            if (press_c[BTN_CAPTURE]) begin
                operand       <= switches[OP_W-1:0];
                mode          <= switches[9:8];
                capture_valid <= 1'b1;
            end
            if (press_c[BTN_VIEW]) begin
                sel <= sel + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_button_input_stage.sv
// Directed self-checking bench for button_input_stage with DB_CYCLES=4, REPEAT_CYCLES=20.
module tb_button_input_stage;

    localparam int unsigned NUM_BTN       = 2;
    localparam int unsigned DB_CYCLES     = 4;
    localparam int unsigned REPEAT_CYCLES = 20;
    localparam int unsigned OP_W          = 8;
`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset_n;
    logic [NUM_BTN-1:0] buttons;
    logic [9:0]         switches;
    logic [NUM_BTN-1:0] press;
    logic [NUM_BTN-1:0] held;
    logic [1:0]         sel;
    logic [OP_W-1:0]    operand;
    logic [1:0]         mode;
    logic               capture_valid;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] exp_sel  = 2'd0;

    button_input_stage #(
        .NUM_BTN       (NUM_BTN),
        .DB_CYCLES     (DB_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES),
        .OP_W          (OP_W)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .buttons       (buttons),
        .switches      (switches),
        .press         (press),
        .held          (held),
        .sel           (sel),
        .operand       (operand),
        .mode          (mode),
        .capture_valid (capture_valid)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        int pulses = 0;
        reset_n  = 1'b0;
        buttons  = 2'b11;
        switches = 10'h000;
        repeat (3) step();
        n_checks++;
        if ({press, held, sel, operand, mode, capture_valid} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %0h expected 0",
                     {press, held, sel, operand, mode, capture_valid});
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            if (press !== 2'b00) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL idle_pulses: got %0d expected 0", pulses);
        end
        n_checks++;
        if (held !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_held: got %0b expected 00", held);
        end
        n_checks++;
        if (sel !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_sel: got %0d expected 0", sel);
        end
        n_checks++;
        if ({operand, mode, capture_valid} !== 11'd0) begin
            n_fail++;
            $display("FAIL idle_capture: got %0h expected 0", {operand, mode, capture_valid});
        end
        exp_sel = 2'd0;
    endtask

    task automatic test_view_press();
        int   pulses = 0;
        logic exp_p;
        @(negedge clock);
        buttons[1] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            exp_p = (k == 7) || (AUTOREP && (k == 27));
            if (press[1]) pulses++;
            if (k == 6 || k == 7 || k == 8 || k == 27) begin
                n_checks++;
                if (press[1] !== exp_p) begin
                    n_fail++;
                    $display("FAIL view_press_k%0d: got %0b expected %0b", k, press[1], exp_p);
                end
            end
            if (k == 6 || k == 7) begin
                n_checks++;
                if (held[1] !== (k == 7)) begin
                    n_fail++;
                    $display("FAIL view_held_k%0d: got %0b expected %0b", k, held[1], (k == 7));
                end
            end
        end
        n_checks++;
        if (pulses !== (AUTOREP ? 2 : 1)) begin
            n_fail++;
            $display("FAIL view_pulse_count: got %0d expected %0d", pulses, (AUTOREP ? 2 : 1));
        end
        exp_sel = exp_sel + (AUTOREP ? 2'd2 : 2'd1);
        n_checks++;
        if (sel !== exp_sel) begin
            n_fail++;
            $display("FAIL view_sel: got %0d expected %0d", sel, exp_sel);
        end
        @(negedge clock);
        buttons[1] = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (press !== 2'b00) pulses++;
            if (k == 6 || k == 7) begin
                n_checks++;
                if (held[1] !== (k == 6)) begin
                    n_fail++;
                    $display("FAIL release_held_k%0d: got %0b expected %0b", k, held[1], (k == 6));
                end
            end
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL release_pulses: got %0d expected 0", pulses);
        end
    endtask

    task automatic test_bounce();
        int pulses = 0;
        switches = 10'b10_1010_0101;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            buttons[0] = 1'b0;
            step(); if (press !== 2'b00) pulses++;
            step(); if (press !== 2'b00) pulses++;
            @(negedge clock);
            buttons[0] = 1'b1;
            step(); if (press !== 2'b00) pulses++;
            step(); if (press !== 2'b00) pulses++;
        end
        n_checks++;
        if (held[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_held: got %0b expected 0", held[0]);
        end
        @(negedge clock);
        buttons[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (press !== 2'b00) pulses++;
            if (k == 6) begin
                n_checks++;
                if ({press[0], capture_valid, operand} !== 10'd0) begin
                    n_fail++;
                    $display("FAIL bounce_pre_capture: got %0h expected 0",
                             {press[0], capture_valid, operand});
                end
            end
            if (k == 7) begin
                n_checks++;
                if (press !== 2'b01) begin
                    n_fail++;
                    $display("FAIL bounce_press: got %0b expected 01", press);
                end
                n_checks++;
                if ({operand, mode, capture_valid} !== {8'hA5, 2'b10, 1'b1}) begin
                    n_fail++;
                    $display("FAIL bounce_capture: got %0h/%0b/%0b expected a5/10/1",
                             operand, mode, capture_valid);
                end
            end
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL bounce_pulse_count: got %0d expected 1", pulses);
        end
        n_checks++;
        if (sel !== exp_sel) begin
            n_fail++;
            $display("FAIL bounce_sel: got %0d expected %0d", sel, exp_sel);
        end
        @(negedge clock);
        buttons[0] = 1'b1;
        repeat (10) step();
    endtask

    task automatic test_wrap();
        @(negedge clock);
        reset_n = 1'b0;
        repeat (2) step();
        @(negedge clock);
        reset_n = 1'b1;
        step();
        exp_sel = 2'd0;
        n_checks++;
        if ({operand, mode, capture_valid, sel} !== 13'd0) begin
            n_fail++;
            $display("FAIL wrap_reset: got %0h expected 0", {operand, mode, capture_valid, sel});
        end
        for (int p = 0; p < 4; p++) begin
            @(negedge clock);
            buttons[1] = 1'b0;
            for (int k = 1; k <= 9; k++) begin
                step();
                if (k == 7) begin
                    n_checks++;
                    if (press !== 2'b10) begin
                        n_fail++;
                        $display("FAIL wrap_press_%0d: got %0b expected 10", p, press);
                    end
                end
            end
            @(negedge clock);
            buttons[1] = 1'b1;
            repeat (9) step();
            exp_sel = exp_sel + 2'd1;
            n_checks++;
            if (sel !== exp_sel) begin
                n_fail++;
                $display("FAIL wrap_sel_%0d: got %0d expected %0d", p, sel, exp_sel);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] sel_before;
        switches   = 10'b01_0011_1100;
        sel_before = exp_sel;
        @(negedge clock);
        buttons = 2'b00;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 7) begin
                n_checks++;
                if (press !== 2'b11) begin
                    n_fail++;
                    $display("FAIL simul_press: got %0b expected 11", press);
                end
                n_checks++;
                if ({operand, mode} !== {8'h3C, 2'b01}) begin
                    n_fail++;
                    $display("FAIL simul_capture: got %0h/%0b expected 3c/01", operand, mode);
                end
                n_checks++;
                if (sel !== sel_before + 2'd1) begin
                    n_fail++;
                    $display("FAIL simul_sel: got %0d expected %0d", sel, sel_before + 2'd1);
                end
            end
            if (k == 8) begin
                n_checks++;
                if (press !== 2'b00) begin
                    n_fail++;
                    $display("FAIL simul_single_cycle: got %0b expected 00", press);
                end
            end
        end
        exp_sel = sel_before + 2'd1;
        @(negedge clock);
        buttons = 2'b11;
        repeat (9) step();
    endtask

    task automatic test_reset_abort();
        int pulses = 0;
        @(negedge clock);
        buttons[1] = 1'b0;
        repeat (4) step();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({press, held, sel, capture_valid} !== 7'd0) begin
            n_fail++;
            $display("FAIL abort_async: got %0h expected 0", {press, held, sel, capture_valid});
        end
        for (int k = 0; k < 3; k++) begin
            step();
            if (press !== 2'b00) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_pulses: got %0d expected 0", pulses);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (press !== 2'b00) pulses++;
            if (k == 6 || k == 7) begin
                n_checks++;
                if (press !== ((k == 7) ? 2'b10 : 2'b00)) begin
                    n_fail++;
                    $display("FAIL abort_repress_k%0d: got %0b expected %0b",
                             k, press, ((k == 7) ? 2'b10 : 2'b00));
                end
            end
        end
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL abort_pulse_count: got %0d expected 1", pulses);
        end
        exp_sel = 2'd1;
        n_checks++;
        if (sel !== exp_sel) begin
            n_fail++;
            $display("FAIL abort_sel: got %0d expected %0d", sel, exp_sel);
        end
        @(negedge clock);
        buttons[1] = 1'b1;
        repeat (9) step();
    endtask

`ifdef BUTTON_AUTOREPEAT_EN
    task automatic test_autorepeat();
        logic exp_p;
        @(negedge clock);
        buttons[1] = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            step();
            exp_p = (k == 7) || (k == 27) || (k == 47) || (k == 67);
            n_checks++;
            if (press[1] !== exp_p) begin
                n_fail++;
                $display("FAIL repeat_k%0d: got %0b expected %0b", k, press[1], exp_p);
            end
        end
        exp_sel = exp_sel + 2'd4;
        n_checks++;
        if (sel !== exp_sel) begin
            n_fail++;
            $display("FAIL repeat_sel: got %0d expected %0d", sel, exp_sel);
        end
        @(negedge clock);
        buttons[1] = 1'b1;
        repeat (9) step();
    endtask
`endif

    initial begin
        test_reset();
        test_view_press();
        test_bounce();
        test_wrap();
        test_simultaneous();
        test_reset_abort();
`ifdef BUTTON_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
